// File: rtl/ternary_pack.sv
// Packs a stream of S3 trits into bytes, five trits per byte in base 3
// (c0 + 3*c1 + 9*c2 + 27*c3 + 81*c4). Output is a single held register.
module ternary_pack #(
  parameter int N_COEF = 700
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_trit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_last,
  output logic       frame_done,
  output logic       err
);

  localparam int TPB     = 5;
  localparam int N_BYTES = N_COEF / TPB;
  localparam int BCW     = $clog2(N_BYTES + 1);

  logic [7:0]     acc_q, acc_d;
  logic [7:0]     w_q, w_d;
  logic [2:0]     trit_cnt_q, trit_cnt_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic           out_valid_q, out_valid_d;
  logic [7:0]     out_byte_q, out_byte_d;
  logic           out_last_q, out_last_d;
  logic           err_q, err_d;

  logic       last_trit;
  logic       accept;
  logic       consume;
  logic [7:0] tw;
  logic [7:0] acc_sum;

  // Valid/ready: a trit moves when in_valid & in_ready, a byte moves when
  // out_valid & out_ready; out_* hold stable while out_valid & !out_ready.
  assign last_trit  = (trit_cnt_q == 3'(TPB - 1));
  assign in_ready   = !(out_valid_q && !out_ready && last_trit);
  assign accept     = in_valid && in_ready;
  assign consume    = out_valid_q && out_ready;

  assign out_valid  = out_valid_q;
  assign out_byte   = out_byte_q;
  assign out_last   = out_last_q;
  assign err        = err_q;
  assign frame_done = consume && out_last_q;

  // t*w using only shifts: t is 0, 1 or 2; the illegal code contributes 0.
  always_comb begin
    tw = 8'd0;
    case (in_trit)
      2'b01:   tw = w_q;
      2'b10:   tw = {w_q[6:0], 1'b0};
      default: tw = 8'd0;
    endcase
  end

  assign acc_sum = acc_q + tw;

  always_comb begin
    acc_d       = acc_q;
    w_d         = w_q;
    trit_cnt_d  = trit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    out_valid_d = out_valid_q;
    out_byte_d  = out_byte_q;
    out_last_d  = out_last_q;
    err_d       = err_q;

    if (consume) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      err_d = err_q | (in_trit == 2'b11);
      if (last_trit) begin
        // A completing byte overrides the consume, so back-to-back bytes
        // flow without a bubble.
        out_byte_d  = acc_sum;
        out_valid_d = 1'b1;
        out_last_d  = (byte_cnt_q == BCW'(N_BYTES - 1));
        acc_d       = 8'd0;
        w_d         = 8'd1;
        trit_cnt_d  = 3'd0;
        byte_cnt_d  = (byte_cnt_q == BCW'(N_BYTES - 1)) ? '0 : byte_cnt_q + BCW'(1);
      end else begin
        acc_d      = acc_sum;
        w_d        = {w_q[6:0], 1'b0} + w_q;
        trit_cnt_d = trit_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q       <= 8'd0;
      w_q         <= 8'd1;
      trit_cnt_q  <= 3'd0;
      byte_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_byte_q  <= 8'd0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      w_q         <= w_d;
      trit_cnt_q  <= trit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_ternary_pack.sv
// Bench for ternary_pack: scenario tasks plus a cycle-level scoreboard that
// rebuilds each byte from the accepted trits with plain base-3 arithmetic.
module tb_ternary_pack;

  localparam int N_COEF  = 700;
  localparam int N_BYTES = N_COEF / 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_trit = 2'b00;
  logic       out_ready = 1'b1;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_byte;
  logic       out_last;
  logic       frame_done;
  logic       err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_consumed = 0;
  int n_fd = 0;
  int rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random

  // Reference model state
  int         trit_buf[$];
  logic [8:0] exp_q[$];  // {last, byte}
  int         byte_idx = 0;
  logic       err_exp = 1'b0;
  int         mv, mpw;
  logic       exp_fd, exp_ir;

  ternary_pack #(.N_COEF(N_COEF)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_trit(in_trit), .out_valid(out_valid), .out_ready(out_ready),
    .out_byte(out_byte), .out_last(out_last), .frame_done(frame_done),
    .err(err)
  );

  // Clock / reset-independent drivers
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (rdy_mode == 0) out_ready = 1'b0;
    else if (rdy_mode == 1) out_ready = 1'b1;
    else out_ready = ($urandom_range(0, 3) != 0);
  end

  // Scoreboard: compare DUT against the model, then advance the model with
  // whatever handshakes happen at the coming edge.
  always @(negedge clk) begin
    if (!rst) begin
      trit_buf.delete();
      exp_q.delete();
      byte_idx = 0;
      err_exp  = 1'b0;
    end else begin
      checks++;
      if (out_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL sb_out_valid t=%0t got=%b exp=%b", $time, out_valid, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        checks++;
        if (out_byte !== exp_q[0][7:0]) begin
          errors++;
          $display("FAIL sb_out_byte t=%0t got=%0d exp=%0d", $time, out_byte, exp_q[0][7:0]);
        end
        checks++;
        if (out_last !== exp_q[0][8]) begin
          errors++;
          $display("FAIL sb_out_last t=%0t got=%b exp=%b", $time, out_last, exp_q[0][8]);
        end
      end
      exp_ir = !((exp_q.size() != 0) && !out_ready && (trit_buf.size() == 4));
      checks++;
      if (in_ready !== exp_ir) begin
        errors++;
        $display("FAIL sb_in_ready t=%0t got=%b exp=%b", $time, in_ready, exp_ir);
      end
      checks++;
      if (err !== err_exp) begin
        errors++;
        $display("FAIL sb_err t=%0t got=%b exp=%b", $time, err, err_exp);
      end
      exp_fd = out_ready && (exp_q.size() != 0) && exp_q[0][8];
      checks++;
      if (frame_done !== exp_fd) begin
        errors++;
        $display("FAIL sb_frame_done t=%0t got=%b exp=%b", $time, frame_done, exp_fd);
      end

      if (out_ready && exp_q.size() != 0) begin
        if (exp_q[0][8]) n_fd++;
        void'(exp_q.pop_front());
        n_consumed++;
      end
      if (in_valid && exp_ir) begin
        if (in_trit == 2'b11) err_exp = 1'b1;
        trit_buf.push_back((in_trit == 2'b11) ? 0 : int'(in_trit));
        if (trit_buf.size() == 5) begin
          mv = 0;
          mpw = 1;
          for (int i = 0; i < 5; i++) begin
            mv  += trit_buf[i] * mpw;
            mpw *= 3;
          end
          exp_q.push_back({(byte_idx == N_BYTES - 1), 8'(mv)});
          byte_idx = (byte_idx + 1) % N_BYTES;
          trit_buf.delete();
        end
      end
    end
  end

  // Driver tasks
  task automatic send_trit(input logic [1:0] t);
    int   budget;
    logic acc;
    in_valid = 1'b1;
    in_trit  = t;
    budget   = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end while (!acc && budget < 200);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout t=%0t trit=%b", $time, t);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
  endtask

  // Scenario tasks
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_byte, out_last, frame_done, err} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b_%h_%b_%b_%b exp=0", out_valid, out_byte, out_last, frame_done, err);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_zeros_frame();
    int c0, f0, t0;
    rdy_mode = 1;
    c0 = n_consumed; f0 = n_fd; t0 = cyc;
    for (int i = 0; i < N_COEF; i++) send_trit(2'b00);
    checks++;
    if (cyc - t0 !== N_COEF) begin
      errors++;
      $display("FAIL zeros_throughput cycles got=%0d exp=%0d", cyc - t0, N_COEF);
    end
    idle(2);
    checks++;
    if (n_consumed - c0 !== N_BYTES) begin
      errors++;
      $display("FAIL zeros_bytes got=%0d exp=%0d", n_consumed - c0, N_BYTES);
    end
    checks++;
    if (n_fd - f0 !== 1) begin
      errors++;
      $display("FAIL zeros_frame_done got=%0d exp=1", n_fd - f0);
    end
  endtask

  task automatic test_all_twos();
    rdy_mode = 1;
    for (int i = 0; i < N_COEF; i++) send_trit(2'b10);
    checks++;
    if ({out_valid, out_last, out_byte} !== {1'b1, 1'b1, 8'hF2}) begin
      errors++;
      $display("FAIL twos_last_byte got=%b_%b_%h exp=1_1_f2", out_valid, out_last, out_byte);
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL twos_frame_done got=%b exp=1", frame_done);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_known_bytes();
    logic [1:0] pat_a[5];
    pat_a = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10};
    rdy_mode = 1;
    for (int i = 0; i < 5; i++) send_trit(pat_a[i]);
    checks++;
    if ({out_valid, out_byte} !== {1'b1, 8'hC4}) begin
      errors++;
      $display("FAIL known_c4 got=%b_%h exp=1_c4", out_valid, out_byte);
    end
    for (int i = 0; i < 4; i++) send_trit(2'b00);
    send_trit(2'b01);
    checks++;
    if ({out_valid, out_byte} !== {1'b1, 8'h51}) begin
      errors++;
      $display("FAIL known_51 got=%b_%h exp=1_51", out_valid, out_byte);
    end
    idle(2);
  endtask

  task automatic test_backpressure();
    int         c0, v, pw;
    logic [1:0] t;
    logic [7:0] byte_a;
    rdy_mode = 0;
    idle(1);
    c0 = n_consumed;
    v = 0;
    pw = 1;
    for (int i = 0; i < 5; i++) begin
      t = 2'($urandom_range(0, 2));
      v += int'(t) * pw;
      pw *= 3;
      send_trit(t);
    end
    byte_a = 8'(v);
    for (int i = 0; i < 4; i++) send_trit(2'($urandom_range(0, 2)));
    in_valid = 1'b1;
    in_trit  = 2'($urandom_range(0, 2));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, out_byte} !== {1'b0, 1'b1, byte_a}) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got=%b_%b_%h exp=0_1_%h", i, in_ready, out_valid, out_byte, byte_a);
      end
      @(posedge clk);
      #1;
    end
    rdy_mode = 1;
    send_trit(in_trit);
    idle(3);
    checks++;
    if (n_consumed - c0 !== 2) begin
      errors++;
      $display("FAIL bp_count got=%0d exp=2", n_consumed - c0);
    end
  endtask

  task automatic test_illegal();
    int k, pw, f0;
    do_reset();
    rdy_mode = 1;
    k = $urandom_range(0, 4);
    pw = 1;
    for (int i = 0; i < k; i++) pw *= 3;
    for (int i = 0; i < 15; i++) send_trit(2'b01);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL illegal_err_before got=%b exp=0", err);
    end
    for (int i = 0; i < 5; i++) send_trit((i == k) ? 2'b11 : 2'b01);
    checks++;
    if (out_byte !== 8'(121 - pw)) begin
      errors++;
      $display("FAIL illegal_byte3 got=%0d exp=%0d", out_byte, 121 - pw);
    end
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_err_set got=%b exp=1", err);
    end
    f0 = n_fd;
    for (int i = 20; i < N_COEF; i++) send_trit(2'($urandom_range(0, 2)));
    idle(2);
    checks++;
    if ({n_fd - f0 == 1, err} !== 2'b11) begin
      errors++;
      $display("FAIL illegal_err_frame_end fd=%0d err=%b exp fd=1 err=1", n_fd - f0, err);
    end
    do_reset();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL illegal_err_reset got=%b exp=0", err);
    end
  endtask

  task automatic test_reset_mid_frame();
    int f0;
    rdy_mode = 1;
    for (int i = 0; i < 12; i++) send_trit(2'($urandom_range(0, 2)));
    do_reset();
    f0 = n_fd;
    for (int i = 0; i < 5; i++) send_trit(2'b01);
    checks++;
    if ({out_valid, out_last, out_byte} !== {1'b1, 1'b0, 8'h79}) begin
      errors++;
      $display("FAIL midrst_first got=%b_%b_%h exp=1_0_79", out_valid, out_last, out_byte);
    end
    for (int i = 5; i < N_COEF; i++) send_trit(2'b00);
    checks++;
    if (out_last !== 1'b1) begin
      errors++;
      $display("FAIL midrst_last got=%b exp=1", out_last);
    end
    idle(2);
    checks++;
    if (n_fd - f0 !== 1) begin
      errors++;
      $display("FAIL midrst_frame_done got=%0d exp=1", n_fd - f0);
    end
  endtask

  task automatic test_random();
    int c0, f0;
    do_reset();
    rdy_mode = 2;
    c0 = n_consumed; f0 = n_fd;
    for (int i = 0; i < 2 * N_COEF; i++) begin
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      send_trit(($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2)));
    end
    in_valid = 1'b0;
    rdy_mode = 1;
    idle(4);
    checks++;
    if (n_consumed - c0 !== 2 * N_BYTES) begin
      errors++;
      $display("FAIL random_bytes got=%0d exp=%0d", n_consumed - c0, 2 * N_BYTES);
    end
    checks++;
    if (n_fd - f0 !== 2) begin
      errors++;
      $display("FAIL random_frames got=%0d exp=2", n_fd - f0);
    end
  endtask

  initial begin
    test_reset();
    test_zeros_frame();
    test_all_twos();
    test_known_bytes();
    test_backpressure();
    test_illegal();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ternary_pack.md
Name: ternary_pack

Overview:
Packs a stream of ternary (S3) polynomial coefficients into bytes, five trits per byte in base 3. It is the inverse-direction companion of the ternary sampler, which turns random bits into trits. The sampler's outputs feed this block when serialising secret polynomials to byte form, as in NTRU-HRSS pack_S3. Byte value = c0 + 3*c1 + 9*c2 + 27*c3 + 81*c4, with c0 the first trit accepted in that group.

Parameters:
N_COEF, 700, trits per frame; must be a multiple of TPB
TPB, 5, trits per output byte; fixed by the format, not for override
N_BYTES, N_COEF/TPB (140), bytes per frame; derived

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  in_trit is valid
in_ready  output  1  block accepts a trit this cycle
in_trit  input  2  coefficient: 00=0, 01=1, 10=2 (i.e. -1), 11=illegal
out_valid  output  1  out_byte is valid
out_ready  input  1  downstream accepts the byte
out_byte  output  8  packed byte, range 0..242
out_last  output  1  qualifies out_valid; marks the final byte of a frame
frame_done  output  1  one-cycle pulse when the last byte is consumed
err  output  1  sticky flag; set on an accepted illegal trit

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0, out_byte=0, out_last=0, frame_done=0, err=0, all accumulators and counters cleared. in_ready=1 once reset is released.
- A trit is accepted when in_valid & in_ready. A byte is consumed when out_valid & out_ready.
- Accumulator acc (8 bits) and weight w (8 bits, one of 1, 3, 9, 27, 81):
  - w=1 and acc=0 at the start of each group.
  - On accept: acc <= acc + t*w and w <= 3*w, with 3*w built as (w<<1)+w. No multiplier.
  - t is the decoded trit value; illegal 11 is treated as 0.
- trit_cnt counts 0..TPB-1. On the accept with trit_cnt=TPB-1:
  - out_byte <= acc + t*w; out_valid <= 1.
  - acc <= 0, w <= 1, trit_cnt <= 0, byte_cnt increments.
  - out_last <= (byte_cnt == N_BYTES-1).
- Latency: a byte is visible on out_byte the cycle after its 5th trit is accepted.
- Single output register:
  - out_valid, out_byte and out_last hold stable until consumed.
  - Accumulation of the next byte continues while the register is held.
- in_ready = !(out_valid & !out_ready & trit_cnt==TPB-1). It stalls only the 5th trit when the output is still occupied.
- Simultaneous consume and new-byte completion in the same cycle: the new byte loads and out_valid stays 1, with no bubble. Sustained throughput is 1 trit per cycle.
- Frame end:
  - When the byte with out_last=1 is consumed: frame_done=1 for that single cycle, byte_cnt <= 0, err is unaffected.
  - The next trit starts a new frame.
  - byte_cnt wraps to 0 at N_BYTES.
- err: set on an accept with in_trit=11. It stays set until reset, and processing continues regardless.
- Reset mid-frame: the partial byte is discarded, the pending output is dropped, and the next accepted trit is c0 of byte 0.
- Width rule: acc never exceeds 242, so no overflow occurs in 8 bits.
- Idle behaviour: no output changes without an accept or consume.

Test Plan:
- 700 trits of 00 with out_ready=1 -> 140 bytes of 0x00, one byte every 5 cycles; out_last and frame_done on byte 140 only.
- 700 trits of 10 -> every byte 0xF2 (242).
- Trits 01,10,00,01,10 -> byte 0xC4 (1+6+0+27+162=196); trits 00,00,00,00,01 -> 0x51 (81).
- out_ready=0 held for 20 cycles while trits stream in -> first byte stays stable; in_ready drops on the 5th trit of the second byte; releasing out_ready loses and duplicates nothing.
- One trit of 11 inside byte 3, others 01 -> byte 3 = 121-w (the illegal trit contributes 0); err=1 and stays set through frame end until rst.
- Assert rst after 12 trits, then send 5 trits of 01 -> first output is 0x79 (121) with out_last=0; byte_cnt has restarted at 0.
